// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB TX packet framer: packet codes, PID/SYNC
// byte values, CRC16 parameters and the framer state encoding.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        PKT_NONE  = 3'd0,
        PKT_DATA0 = 3'd1,
        PKT_DATA1 = 3'd2,
        PKT_ACK   = 3'd3,
        PKT_NAK   = 3'd4,
        PKT_STALL = 3'd5
    } tx_pkt_t;

    localparam logic [7:0] SYNC_BYTE = 8'h80;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;

    localparam logic [15:0] CRC16_POLY = 16'hA001;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_SYNC   = 4'd1,
        ST_PID    = 4'd2,
        ST_FETCH  = 4'd3,
        ST_WAIT   = 4'd4,
        ST_DATA   = 4'd5,
        ST_CRC_LO = 4'd6,
        ST_CRC_HI = 4'd7,
        ST_DONE   = 4'd8
    } framer_state_t;

    function automatic logic [7:0] pid_of(input tx_pkt_t pkt);
        logic [7:0] pid;
        case (pkt)
            PKT_DATA0: pid = PID_DATA0;
            PKT_DATA1: pid = PID_DATA1;
            PKT_ACK:   pid = PID_ACK;
            PKT_NAK:   pid = PID_NAK;
            PKT_STALL: pid = PID_STALL;
            default:   pid = 8'h00;
        endcase
        return pid;
    endfunction

    function automatic logic is_handshake(input tx_pkt_t pkt);
        logic hs;
        case (pkt)
            PKT_ACK, PKT_NAK, PKT_STALL: hs = 1'b1;
            default:                     hs = 1'b0;
        endcase
        return hs;
    endfunction

endpackage

// File: rtl/usb_crc16_byte.sv
// One-byte update of the USB data CRC16 (reflected polynomial, LSB first).
// Purely combinational; the caller owns the CRC register.
module usb_crc16_byte
    import usb_tx_pkg::*;
(
    input  logic [15:0] crc_cur,
    input  logic [7:0]  data,
    output logic [15:0] crc_next
);

    logic [15:0] crc_work_s;

    // Eight shift/xor steps, one per data bit, starting at bit 0
    always_comb begin
        crc_work_s = crc_cur ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            if (crc_work_s[0]) begin
                crc_work_s = (crc_work_s >> 1) ^ CRC16_POLY;
            end else begin
                crc_work_s = crc_work_s >> 1;
            end
        end
        crc_next = crc_work_s;
    end

endmodule

// File: rtl/usb_tx_packet_framer.sv
// Frames one USB packet (SYNC, PID, payload, CRC16) as a valid/ready byte stream.
// Optional feature: define TX_FRAMER_PKT_CNT_EN to add the pkt_count output.
module usb_tx_packet_framer
    import usb_tx_pkg::*;
#(
    parameter int MAX_PAYLOAD = 64
) (
    input  logic        clk,
    input  logic        rst,
`ifdef TX_FRAMER_PKT_CNT_EN
    output logic [15:0] pkt_count,
`endif
    input  logic        tx_start,
    input  logic [2:0]  tx_packet,
    input  logic [6:0]  buffer_occupancy,
    input  logic [7:0]  tx_packet_data,
    output logic        get_tx_packet_data,
    output logic [7:0]  tx_byte,
    output logic        tx_byte_valid,
    input  logic        tx_byte_ready,
    output logic        tx_byte_last,
    output logic        tx_busy,
    output logic        tx_done
);

    localparam logic [6:0] MAX_LEN = 7'(MAX_PAYLOAD);

    framer_state_t state_r;
    tx_pkt_t       pkt_r;
    logic [6:0]    len_r;
    logic [15:0]   crc_r;
    logic [7:0]    byte_r;
    logic          valid_r;
    logic          last_r;
    logic          get_r;
    logic          busy_r;
    logic          done_r;

    logic          start_ok_s;
    logic [6:0]    start_len_s;
    logic          accept_s;
    logic [15:0]   crc_next_s;

    usb_crc16_byte u_crc (
        .crc_cur  (crc_r),
        .data     (byte_r),
        .crc_next (crc_next_s)
    );

    // Start qualification, clipped length and byte-accept decode
    always_comb begin
        start_ok_s  = tx_start && (tx_packet >= 3'd1) && (tx_packet <= 3'd5);
        accept_s    = valid_r && tx_byte_ready;
        if (buffer_occupancy > MAX_LEN) begin
            start_len_s = MAX_LEN;
        end else begin
            start_len_s = buffer_occupancy;
        end
    end

    // Framer FSM with registered byte, handshake and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            pkt_r   <= PKT_NONE;
            len_r   <= 7'd0;
            crc_r   <= CRC16_INIT;
            byte_r  <= 8'h00;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            get_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r  <= 1'b0;
                    get_r   <= 1'b0;
                    last_r  <= 1'b0;
                    if (start_ok_s) begin
                        pkt_r   <= tx_pkt_t'(tx_packet);
                        len_r   <= start_len_s;
                        crc_r   <= CRC16_INIT;
                        busy_r  <= 1'b1;
                        byte_r  <= SYNC_BYTE;
                        valid_r <= 1'b1;
                        state_r <= ST_SYNC;
                    end else begin
                        valid_r <= 1'b0;
                    end
                end
                ST_SYNC: begin
                    if (accept_s) begin
                        byte_r  <= pid_of(pkt_r);
                        last_r  <= is_handshake(pkt_r);
                        state_r <= ST_PID;
                    end
                end
                ST_PID: begin
                    if (accept_s) begin
                        if (is_handshake(pkt_r)) begin
                            byte_r  <= 8'h00;
                            valid_r <= 1'b0;
                            last_r  <= 1'b0;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else if (len_r == 7'd0) begin
                            byte_r  <= ~crc_r[7:0];
                            state_r <= ST_CRC_LO;
                        end else begin
                            valid_r <= 1'b0;
                            get_r   <= 1'b1;
                            state_r <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    get_r   <= 1'b0;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Buffer read data is valid in the cycle after the pop
                    byte_r  <= tx_packet_data;
                    valid_r <= 1'b1;
                    state_r <= ST_DATA;
                end
                ST_DATA: begin
                    if (accept_s) begin
                        crc_r <= crc_next_s;
                        len_r <= len_r - 7'd1;
                        if (len_r == 7'd1) begin
                            byte_r  <= ~crc_next_s[7:0];
                            state_r <= ST_CRC_LO;
                        end else begin
                            valid_r <= 1'b0;
                            get_r   <= 1'b1;
                            state_r <= ST_FETCH;
                        end
                    end
                end
                ST_CRC_LO: begin
                    if (accept_s) begin
                        byte_r  <= ~crc_r[15:8];
                        last_r  <= 1'b1;
                        state_r <= ST_CRC_HI;
                    end
                end
                ST_CRC_HI: begin
                    if (accept_s) begin
                        byte_r  <= 8'h00;
                        valid_r <= 1'b0;
                        last_r  <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    byte_r  <= 8'h00;
                    valid_r <= 1'b0;
                    last_r  <= 1'b0;
                    get_r   <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef TX_FRAMER_PKT_CNT_EN
    logic [15:0] pkt_count_r;

    // Completed-packet counter, wraps naturally at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count_r <= 16'h0000;
        end else if (done_r) begin
            pkt_count_r <= pkt_count_r + 16'h0001;
        end else begin
            pkt_count_r <= pkt_count_r;
        end
    end

    assign pkt_count = pkt_count_r;
`endif

    assign tx_byte            = byte_r;
    assign tx_byte_valid      = valid_r;
    assign tx_byte_last       = last_r;
    assign get_tx_packet_data = get_r;
    assign tx_busy            = busy_r;
    assign tx_done            = done_r;

endmodule

// File: tb/tb_usb_tx_packet_framer.sv
// Directed self-checking bench for usb_tx_packet_framer with a buffer model,
// a byte/pop monitor and a bit-serial CRC16 reference.
module tb_usb_tx_packet_framer;

    logic        clk;
    logic        rst;
    logic        tx_start;
    logic [2:0]  tx_packet;
    logic [6:0]  buffer_occupancy;
    logic [7:0]  tx_packet_data;
    logic        get_tx_packet_data;
    logic [7:0]  tx_byte;
    logic        tx_byte_valid;
    logic        tx_byte_ready;
    logic        tx_byte_last;
    logic        tx_busy;
    logic        tx_done;
`ifdef TX_FRAMER_PKT_CNT_EN
    logic [15:0] pkt_count;
`endif

    usb_tx_packet_framer dut (
        .clk                (clk),
        .rst                (rst),
`ifdef TX_FRAMER_PKT_CNT_EN
        .pkt_count          (pkt_count),
`endif
        .tx_start           (tx_start),
        .tx_packet          (tx_packet),
        .buffer_occupancy   (buffer_occupancy),
        .tx_packet_data     (tx_packet_data),
        .get_tx_packet_data (get_tx_packet_data),
        .tx_byte            (tx_byte),
        .tx_byte_valid      (tx_byte_valid),
        .tx_byte_ready      (tx_byte_ready),
        .tx_byte_last       (tx_byte_last),
        .tx_busy            (tx_busy),
        .tx_done            (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] mem [0:127];
    int         rd_idx = 0;
    logic [7:0] byte_q [$];
    bit         last_q [$];
    logic [7:0] exp_q [$];
    int cyc = 0, get_cnt = 0, done_cnt = 0, last_acc_cyc = 0, done_cyc = 0;
    int stall_err = 0, get_run_err = 0, busy_err = 0;
    logic       prev_stall = 1'b0, prev_last = 1'b0, prev_get = 1'b0;
    logic [7:0] prev_byte = 8'h00;

    // Buffer model: data appears one cycle after each pop
    always @(posedge clk) begin
        if (!rst && get_tx_packet_data) begin
            #1;
            tx_packet_data = mem[rd_idx];
            rd_idx++;
        end
    end

    // Monitor: records accepted bytes, pops, done pulses and protocol errors
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 1'b0;
            prev_get   = 1'b0;
        end else begin
            if (prev_stall && (!tx_byte_valid || tx_byte !== prev_byte || tx_byte_last !== prev_last))
                stall_err++;
            prev_stall = tx_byte_valid && !tx_byte_ready;
            prev_byte  = tx_byte;
            prev_last  = tx_byte_last;
            if (tx_byte_valid && tx_byte_ready) begin
                byte_q.push_back(tx_byte);
                last_q.push_back(tx_byte_last);
                last_acc_cyc = cyc;
            end
            if (get_tx_packet_data) get_cnt++;
            if (get_tx_packet_data && prev_get) get_run_err++;
            prev_get = get_tx_packet_data;
            if (tx_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (tx_done && tx_busy) busy_err++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pid_exp(input logic [2:0] t);
        case (t)
            3'd1:    return 8'hC3;
            3'd2:    return 8'h4B;
            3'd3:    return 8'hD2;
            3'd4:    return 8'h5A;
            default: return 8'h1E;
        endcase
    endfunction

    function automatic logic [15:0] crc_model(input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ mem[k][b];
                c  = {1'b0, c[15:1]};
                if (fb) c = c ^ 16'hA001;
            end
        end
        return c;
    endfunction

    task automatic start_pkt(input logic [2:0] t, input logic [6:0] occ);
        @(posedge clk); #1;
        tx_packet = t;
        buffer_occupancy = occ;
        tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input bit rnd, input bit hold);
        int d0 = done_cnt;
        tx_start = hold;
        for (int i = 0; i < budget && done_cnt == d0; i++) begin
            @(posedge clk); #1;
            if (rnd) tx_byte_ready = 1'($urandom_range(0, 1));
        end
        tx_start = 1'b0;
        tx_byte_ready = 1'b1;
        chk({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic run_pkt(input string tag, input logic [2:0] t, input logic [6:0] occ,
                           input int n, input bit rnd, input bit hold);
        bit is_data;
        logic [15:0] c;
        byte_q.delete();
        last_q.delete();
        get_cnt = 0;
        rd_idx = 0;
        start_pkt(t, occ);
        @(negedge clk);
        chk({tag, "_lat_valid"}, 32'(tx_byte_valid), 32'd1);
        chk({tag, "_lat_sync"}, 32'(tx_byte), 32'h80);
        if (hold) begin
            tx_packet = 3'd3;
            buffer_occupancy = 7'd100;
        end
        wait_done(tag, 3000, rnd, hold);
        chk({tag, "_done_lat"}, 32'(done_cyc - last_acc_cyc), 32'd1);
        chk({tag, "_done_pulse"}, 32'(tx_done), 32'd0);
        chk({tag, "_busy_low"}, 32'(tx_busy), 32'd0);
        is_data = (t == 3'd1) || (t == 3'd2);
        exp_q.delete();
        exp_q.push_back(8'h80);
        exp_q.push_back(pid_exp(t));
        if (is_data) begin
            for (int k = 0; k < n; k++) exp_q.push_back(mem[k]);
            c = crc_model(n);
            exp_q.push_back(~c[7:0]);
            exp_q.push_back(~c[15:8]);
        end
        chk({tag, "_nbytes"}, 32'(byte_q.size()), 32'(exp_q.size()));
        if (byte_q.size() == exp_q.size()) begin
            for (int k = 0; k < exp_q.size(); k++) begin
                chk($sformatf("%s_b%0d", tag, k), 32'(byte_q[k]), 32'(exp_q[k]));
                chk($sformatf("%s_l%0d", tag, k), 32'(last_q[k]), 32'(k == exp_q.size() - 1));
            end
        end
        chk({tag, "_pops"}, 32'(get_cnt), 32'(n));
        chk({tag, "_stall"}, 32'(stall_err), 32'd0);
        chk({tag, "_getrun"}, 32'(get_run_err), 32'd0);
        chk({tag, "_busydone"}, 32'(busy_err), 32'd0);
    endtask

    initial begin
        int gets_at_rst;
        rst = 1'b1;
        tx_start = 1'b0;
        tx_packet = 3'd0;
        buffer_occupancy = 7'd0;
        tx_packet_data = 8'h00;
        tx_byte_ready = 1'b1;
        for (int k = 0; k < 128; k++) mem[k] = 8'(k * 37 + 11);

        // Reset state
        @(negedge clk);
        chk("rst_byte", 32'(tx_byte), 32'h0);
        chk("rst_valid", 32'(tx_byte_valid), 32'd0);
        chk("rst_last", 32'(tx_byte_last), 32'd0);
        chk("rst_get", 32'(get_tx_packet_data), 32'd0);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_done", 32'(tx_done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Handshake packets
        run_pkt("ack", 3'd3, 7'd5, 0, 1'b0, 1'b0);
        run_pkt("nak", 3'd4, 7'd0, 0, 1'b0, 1'b0);
        run_pkt("stall", 3'd5, 7'd0, 0, 1'b0, 1'b0);

        // Zero-length DATA0
        run_pkt("zlp", 3'd1, 7'd0, 0, 1'b0, 1'b0);

        // DATA1 with 01 02 03 04
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
        run_pkt("d1x4", 3'd2, 7'd4, 4, 1'b0, 1'b0);

        // Full 64-byte payload under random backpressure
        for (int k = 0; k < 128; k++) mem[k] = 8'($urandom_range(0, 255));
        run_pkt("d0x64", 3'd1, 7'd64, 64, 1'b1, 1'b0);

        // Occupancy above the limit is clipped
        run_pkt("clip", 3'd1, 7'd127, 64, 1'b0, 1'b0);

        // Invalid and NONE starts are ignored
        byte_q.delete();
        get_cnt = 0;
        start_pkt(3'd6, 7'd4);
        start_pkt(3'd0, 7'd4);
        start_pkt(3'd7, 7'd4);
        repeat (4) @(posedge clk);
        #1;
        chk("inv_busy", 32'(tx_busy), 32'd0);
        chk("inv_bytes", 32'(byte_q.size()), 32'd0);
        chk("inv_pops", 32'(get_cnt), 32'd0);

        // tx_start held through busy and DONE, type/occupancy changed mid-packet
        run_pkt("hold", 3'd1, 7'd4, 4, 1'b0, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        chk("hold_after_busy", 32'(tx_busy), 32'd0);
        chk("hold_after_bytes", 32'(byte_q.size()), 32'd8);

        // Reset mid-payload
        byte_q.delete();
        get_cnt = 0;
        rd_idx = 0;
        start_pkt(3'd1, 7'd8);
        for (int i = 0; i < 200 && get_cnt < 3; i++) begin
            @(posedge clk); #1;
        end
        chk("mid_reached", 32'(get_cnt >= 3), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_byte", 32'(tx_byte), 32'h0);
        chk("mid_valid", 32'(tx_byte_valid), 32'd0);
        chk("mid_last", 32'(tx_byte_last), 32'd0);
        chk("mid_get", 32'(get_tx_packet_data), 32'd0);
        chk("mid_busy", 32'(tx_busy), 32'd0);
        chk("mid_done", 32'(tx_done), 32'd0);
        gets_at_rst = get_cnt;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_nopop", 32'(get_cnt), 32'(gets_at_rst));
        chk("mid_idle", 32'(tx_busy), 32'd0);
        run_pkt("after_rst", 3'd1, 7'd2, 2, 1'b0, 1'b0);

`ifdef TX_FRAMER_PKT_CNT_EN
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("cnt_rst", 32'(pkt_count), 32'd0);
        run_pkt("cnt1", 3'd3, 7'd0, 0, 1'b0, 1'b0);
        run_pkt("cnt2", 3'd4, 7'd0, 0, 1'b0, 1'b0);
        run_pkt("cnt3", 3'd1, 7'd0, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("cnt_three", 32'(pkt_count), 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
